serial_subtractor_128: RTL and testbench
========================================

Name: serial_subtractor_128

Overview:
Bit-serial two's-complement subtractor that computes Result = A - B, least-significant bit first, using one full-adder slice: B is inverted and the initial carry-in is 1. It is the inverse-direction companion to the ALU's parallel adder path. It is an area-cheap subtract unit for the 128-bit ALU, with a start/busy/done handshake so the ALU control can launch an operation and wait on it.

Parameters:
WIDTH, 128, operand/result width in bits (>=2); latency scales with it.

Ports:
Clk  input  1  rising-edge clock
Reset_n  input  1  asynchronous active-low reset
Start  input  1  request; accepted on a rising Clk edge when Busy=0
A  input  WIDTH  minuend; sampled only on the accepting edge
B  input  WIDTH  subtrahend; sampled only on the accepting edge
Busy  output  1  high while a subtraction is in progress
Done  output  1  one-cycle pulse: Result and flags are valid
Result  output  WIDTH  A - B modulo 2^WIDTH
Borrow  output  1  1 when A < B unsigned (inverted final carry)
Overflow  output  1  signed overflow of A - B
Zero  output  1  1 when Result == 0

Behaviour:
- Reset (Reset_n=0, asynchronous): FSM goes to IDLE; bit counter is cleared; shift registers, Result, Borrow, Overflow, Zero, Busy and Done all go to 0. An in-flight operation is abandoned with no Done.
- FSM states are IDLE, RUN and DONE.
  - IDLE: Start=1 at an edge latches A and B into shift registers, sets carry=1, zero_acc=1, count=0 and moves to RUN. Start=0 stays in IDLE.
  - RUN: each edge forms s = a[0] ^ ~b[0] ^ carry and carry_next = majority(a[0], ~b[0], carry). It shifts s into the result register from the MSB side, shifts both operand registers right by one, does zero_acc &= ~s and increments count.
  - RUN exit: on the edge where count == WIDTH-1, the final bit is processed and the FSM moves to DONE.
  - DONE: lasts exactly one cycle. Start=1 here is accepted exactly as in IDLE (back-to-back operation); otherwise the FSM goes to IDLE.
- Outputs are registered:
  - Busy = 1 in RUN only.
  - Done = 1 in DONE only.
  - Result, Borrow = ~carry_final, Zero = zero_acc and Overflow = (A_msb != B_msb) && (Result_msb != A_msb) are updated on the edge entering DONE. They hold until the edge entering the next DONE.
  - The MSBs of A and B are captured at Start.
- Latency: Start accepted at edge k means Busy=1 after edges k+1 through k+WIDTH-1, and Done=1 in the cycle after edge k+WIDTH. This gives exactly WIDTH cycles from acceptance to Done.
- Start while Busy=1 is ignored; no queuing. A and B may change freely after the accepting edge.
- Result arithmetic is modulo 2^WIDTH:
  - 0 - 1 gives all ones with Borrow=1.
  - For A == B: Result=0, Zero=1, Borrow=0.
- Reset asserted in the same cycle as Start: reset wins.
- Reset deasserted asynchronously is sampled cleanly; the block does no internal synchronization (the system provides it).

Test Plan:
1. Reset then idle: Reset_n low for 3 cycles, then high with Start=0 for 5 cycles -> Busy=Done=Result=Borrow=Overflow=Zero=0 throughout.
2. Basic subtract: A=300, B=45 (WIDTH=128), Start for 1 cycle -> Busy high for 127 cycles, Done pulses exactly 128 cycles after acceptance, Result=255, Borrow=0, Zero=0, Overflow=0.
3. Underflow/equality: A=0, B=1 -> Result=2^128-1, Borrow=1. Then A=B=0xDEADBEEF -> Result=0, Zero=1, Borrow=0.
4. Signed overflow: A=0x7FFF...F, B=0xFFFF...F (-1) -> Result=0x8000...0, Overflow=1. Also A=0x8000...0, B=1 -> Result=0x7FFF...F, Overflow=1.
5. Handshake: Start held high during RUN with different A/B -> ignored, first result intact. Start asserted in the DONE cycle -> accepted, second Done exactly WIDTH cycles later.
6. Reset mid-operation: Reset_n pulsed low at cycle 50 of RUN -> all outputs 0 immediately, no Done; the next Start (A=10, B=3) yields Result=7.

Source files
------------

// File: rtl/serial_subtractor_128.sv
// Bit-serial two's-complement subtractor computing result = a - b.
// One full-adder slice runs LSB first on a and ~b, with an initial carry of 1.
// A start/busy/done handshake lets the ALU control launch an operation and wait for it.
module serial_subtractor_128 #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_sh_reg;
  logic             carry_reg;
  logic             zero_acc_reg;
  logic             a_msb_reg;
  logic             b_msb_reg;

  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] result_reg;
  logic             borrow_reg;
  logic             overflow_reg;
  logic             zero_reg;

  logic             accept;
  logic             last_bit;
  logic             nb0;
  logic             sum_bit;
  logic             carry_next;

  // An operation can be launched from IDLE or from the single DONE cycle (back-to-back).
  assign accept   = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign last_bit = (state_reg == RUN) && (count_reg == LAST_COUNT);

  // Full-adder slice on a[0] and inverted b[0].
  assign nb0        = ~b_sh_reg[0];
  assign sum_bit    = a_sh_reg[0] ^ nb0 ^ carry_reg;
  assign carry_next = (a_sh_reg[0] & nb0) | (a_sh_reg[0] & carry_reg) | (nb0 & carry_reg);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Serial datapath: operand shifters, carry, zero accumulator and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg    <= '0;
      a_sh_reg     <= '0;
      b_sh_reg     <= '0;
      res_sh_reg   <= '0;
      carry_reg    <= 1'b0;
      zero_acc_reg <= 1'b0;
      a_msb_reg    <= 1'b0;
      b_msb_reg    <= 1'b0;
    end else if (accept) begin
      count_reg    <= '0;
      a_sh_reg     <= a;
      b_sh_reg     <= b;
      carry_reg    <= 1'b1;
      zero_acc_reg <= 1'b1;
      a_msb_reg    <= a[WIDTH-1];
      b_msb_reg    <= b[WIDTH-1];
    end else if (state_reg == RUN) begin
      count_reg    <= count_reg + CW'(1);
      a_sh_reg     <= {1'b0, a_sh_reg[WIDTH-1:1]};
      b_sh_reg     <= {1'b0, b_sh_reg[WIDTH-1:1]};
      res_sh_reg   <= {sum_bit, res_sh_reg[WIDTH-1:1]};
      carry_reg    <= carry_next;
      zero_acc_reg <= zero_acc_reg & ~sum_bit;
    end
  end

  // Registered handshake and result/flag outputs; results load on the edge entering DONE.
  // busy rises one cycle after acceptance and drops on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      result_reg   <= '0;
      borrow_reg   <= 1'b0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
    end else begin
      busy_reg <= (state_reg == RUN) && !last_bit;
      done_reg <= last_bit;
      if (last_bit) begin
        result_reg   <= {sum_bit, res_sh_reg[WIDTH-1:1]};
        borrow_reg   <= ~carry_next;
        zero_reg     <= zero_acc_reg & ~sum_bit;
        overflow_reg <= (a_msb_reg != b_msb_reg) && (sum_bit != a_msb_reg);
      end
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign result   = result_reg;
  assign borrow   = borrow_reg;
  assign overflow = overflow_reg;
  assign zero     = zero_reg;

endmodule

// File: tb/tb_serial_subtractor_128.sv
// Self-checking bench for serial_subtractor_128: directed vector table, handshake
// corner cases and randomized operands checked against an arithmetic reference model.
module tb_serial_subtractor_128;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, borrow, overflow, zero;
  logic [W-1:0] result;

  int tests = 0;
  int fails = 0;

  serial_subtractor_128 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .borrow(borrow),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         brw;
    logic         ovf;
    logic         zro;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact difference computed at W+1 bits, unsigned and signed.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       output logic [W-1:0] r, output logic br, output logic ov, output logic z);
    logic [W:0] sx;
    r  = ma - mb;
    br = (ma < mb);
    sx = {ma[W-1], ma} - {mb[W-1], mb};
    ov = (sx[W] != sx[W-1]);
    z  = (r == '0);
  endtask

  // Present operands with start high across one edge (the accepting edge).
  task automatic launch(input logic [W-1:0] la, input logic [W-1:0] lb, input bit hold);
    start = 1'b1;
    a = la;
    b = lb;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  // Count edges after acceptance until done, checking busy length and done latency.
  task automatic wait_done(input string tag);
    int n = 0;
    int busy_cnt = 0;
    bit seen = 0;
    for (int i = 1; i <= 2 * W + 8; i++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (done) begin
        n = i;
        seen = 1;
        break;
      end
    end
    check({tag, " done_seen"}, W'(seen), W'(1));
    check({tag, " done_latency"}, W'(n), W'(W));
    check({tag, " busy_cycles"}, W'(busy_cnt), W'(W - 1));
  endtask

  task automatic check_outputs(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb);
    logic [W-1:0] r;
    logic br, ov, z;
    model(ea, eb, r, br, ov, z);
    check({tag, " result"}, result, r);
    check({tag, " flags{borrow,ovf,zero}"}, W'({borrow, overflow, zero}), W'({br, ov, z}));
    $display("[TB] %s a=%h b=%h result=%h borrow=%0b ovf=%0b zero=%0b", tag, ea, eb, result, borrow, overflow, zero);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [W-1:0] all1, msb1;

    all1 = '1;
    msb1 = '0;
    msb1[W-1] = 1'b1;

    vecs[0] = '{a: W'(300), b: W'(45), res: W'(255), brw: 1'b0, ovf: 1'b0, zro: 1'b0};
    vecs[1] = '{a: W'(0), b: W'(1), res: all1, brw: 1'b1, ovf: 1'b0, zro: 1'b0};
    vecs[2] = '{a: W'(32'hDEADBEEF), b: W'(32'hDEADBEEF), res: '0, brw: 1'b0, ovf: 1'b0, zro: 1'b1};
    vecs[3] = '{a: ~msb1, b: all1, res: msb1, brw: 1'b1, ovf: 1'b1, zro: 1'b0};
    vecs[4] = '{a: msb1, b: W'(1), res: ~msb1, brw: 1'b0, ovf: 1'b1, zro: 1'b0};
    vecs[5] = '{a: W'(5), b: W'(7), res: all1 - W'(1), brw: 1'b1, ovf: 1'b0, zro: 1'b0};

    // Reset held for 3 cycles, then 5 idle cycles: everything stays zero.
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {result[W-1:5], busy, done, borrow, overflow, zero} | W'(result[4:0]), '0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("idle%0d outputs", i), W'({busy, done, borrow, overflow, zero}) | result, '0);
    end

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].a, vecs[i].b, 0);
      wait_done($sformatf("vec%0d", i));
      check($sformatf("vec%0d result", i), result, vecs[i].res);
      check($sformatf("vec%0d flags{borrow,ovf,zero}", i), W'({borrow, overflow, zero}),
            W'({vecs[i].brw, vecs[i].ovf, vecs[i].zro}));
      $display("[TB] vec%0d a=%h b=%h result=%h borrow=%0b ovf=%0b zero=%0b",
               i, vecs[i].a, vecs[i].b, result, borrow, overflow, zero);
      @(posedge clk); #1;
      check($sformatf("vec%0d done_one_cycle", i), W'(done), '0);
    end

    // Start held high through RUN with other operands: ignored.
    launch(W'(1000), W'(1), 1);
    a = W'(77);
    b = W'(99);
    wait_done("hold");
    start = 1'b0;
    check("hold result", result, W'(999));
    $display("[TB] hold a=1000 b=1 result=%0d", result);
    @(posedge clk); #1;
    check("hold back_to_idle", W'({busy, done}), '0);

    // Start asserted in the DONE cycle: accepted back-to-back.
    launch(W'(50), W'(8), 0);
    wait_done("b2b_first");
    check_outputs("b2b_first", W'(50), W'(8));
    launch(W'(8), W'(50), 0);
    wait_done("b2b_second");
    check_outputs("b2b_second", W'(8), W'(50));

    // Reset pulsed in the middle of RUN: outputs clear at once, no done follows.
    launch(W'(12345), W'(345), 0);
    repeat (50) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset outputs", W'({busy, done, borrow, overflow, zero}) | result, '0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) begin
        check("midreset no_activity", W'({busy, done}), '0);
        break;
      end
    end
    check("midreset quiet_after", W'({busy, done}), '0);
    launch(W'(10), W'(3), 0);
    wait_done("after_reset");
    check("after_reset result", result, W'(7));
    $display("[TB] after_reset a=10 b=3 result=%0d", result);

    // Randomized operands against the reference model.
    for (int t = 0; t < 20; t++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      if (t % 5 == 1) rb = ra;
      if (t % 5 == 2) begin
        ra = W'($urandom_range(0, 15));
        rb = W'($urandom_range(0, 15));
      end
      launch(ra, rb, 0);
      wait_done($sformatf("rnd%0d", t));
      check_outputs($sformatf("rnd%0d", t), ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
